// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter that shares one FIFO write port among NUM_REQ
// producers. One requester owns the port at a time, for a burst of up to
// BURST_LEN accepted beats. The owner's data is muxed onto the FIFO write
// interface and each accepted beat is acknowledged back to that producer.
// A full FIFO stalls the burst without releasing the grant.
//
// Handshake: a beat from requester i is transferred in a cycle exactly when
// o_ack[i] is high, which requires o_gnt[i], i_req[i] and ~i_fifo_full.
// In that same cycle o_fifo_we is high and o_fifo_wdata carries that beat.
// A producer holds i_data steady while i_req is high and it is not acked.
//
// Ports:
//   clk           clock, rising edge
//   rstn          asynchronous reset, active HIGH
//   i_req         per-requester level request
//   i_data        requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_fifo_full   FIFO full flag
//   o_gnt         registered one-hot grant, zero when idle
//   o_ack         per-requester beat accepted this cycle (combinational)
//   o_fifo_we     FIFO write enable (combinational)
//   o_fifo_wdata  owner's data, zero when there is no owner
//   o_busy        high while in BUSY; this is the FSM state observable
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic                          i_fifo_full,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_fifo_we,
    output logic [DATA_WIDTH-1:0]         o_fifo_wdata,
    output logic                          o_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q,    state_d;
    logic [NUM_REQ-1:0]   gnt_q,      gnt_d;
    logic [PTR_W-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic [PTR_W-1:0]     owner_idx;
    logic [PTR_W-1:0]     owner_next;
    logic [PTR_W-1:0]     pick_start;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 accept;
    logic                 release_gnt;

    // Binary index of the current owner (gnt_q is one-hot or zero).
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    assign owner_next = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;

    // When releasing, the search starts just past the old owner so the old
    // owner is considered last; from IDLE it starts at the saved pointer.
    assign pick_start = (state_q == BUSY) ? owner_next : rr_ptr_q;

    // Round-robin pick: iterate from the far end so the index closest to
    // pick_start is the last assignment and therefore wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(pick_start) + k) % NUM_REQ;
            if (i_req[j]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(j);
            end
        end
    end

    assign accept      = (state_q == BUSY) && i_req[owner_idx] && !i_fifo_full;
    assign release_gnt = (state_q == BUSY) &&
                         (!i_req[owner_idx] || (accept && beat_cnt_q == LAST_BEAT));

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = BUSY;
                    gnt_d             = '0;
                    gnt_d[pick_idx]   = 1'b1;
                    beat_cnt_d        = '0;
                end
            end
            BUSY: begin
                if (release_gnt) begin
                    rr_ptr_d   = owner_next;
                    beat_cnt_d = '0;
                    gnt_d      = '0;
                    if (pick_valid) begin
                        // Zero-bubble hand-over to the next winner.
                        gnt_d[pick_idx] = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Data mux follows the grant even while stalled; zero with no owner.
    always_comb begin
        o_fifo_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                o_fifo_wdata = o_fifo_wdata | i_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_gnt     = gnt_q;
    assign o_ack     = accept ? gnt_q : '0;
    assign o_fifo_we = accept;
    assign o_busy    = (state_q == BUSY);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Drives directed scenarios followed by random request/full traffic. A
// reference model tracks the owner, its accepted-beat count and the
// round-robin start point as plain integers; it checks the grant every
// cycle and pushes each expected FIFO write into exp_q. A separate monitor
// pops exp_q whenever the DUT writes (or when a write was expected).
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic             clk;
    logic             rstn;
    logic [N-1:0]     i_req;
    logic [N*W-1:0]   i_data;
    logic             i_fifo_full;
    logic [N-1:0]     o_gnt;
    logic [N-1:0]     o_ack;
    logic             o_fifo_we;
    logic [W-1:0]     o_fifo_wdata;
    logic             o_busy;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .BURST_LEN  (BURST)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_req        (i_req),
        .i_data       (i_data),
        .i_fifo_full  (i_fifo_full),
        .o_gnt        (o_gnt),
        .o_ack        (o_ack),
        .o_fifo_we    (o_fifo_we),
        .o_fifo_wdata (o_fifo_wdata),
        .o_busy       (o_busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt [N];

    logic [N+W-1:0] exp_q[$];

    // Reference model state: owner index (-1 = nobody), beats accepted in
    // the current grant, and where the next round-robin search begins.
    int           m_owner = -1;
    int           m_beats = 0;
    int           m_ptr   = 0;
    logic [N-1:0] acked_mask = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    // ---------------- reference model (negedge) ----------------
    always @(negedge clk) begin
        if (rstn) begin
            m_owner    = -1;
            m_beats    = 0;
            m_ptr      = 0;
            acked_mask = '0;
        end else begin
            logic [N-1:0] exp_gnt;
            logic [W-1:0] exp_wd;
            logic [N-1:0] oh;
            bit           acc;
            exp_gnt = '0;
            exp_wd  = '0;
            if (m_owner >= 0) begin
                exp_gnt[m_owner] = 1'b1;
                exp_wd = i_data[m_owner*W +: W];
            end
            chk("gnt", 32'(o_gnt), 32'(exp_gnt));
            chk("busy", 32'(o_busy), 32'(m_owner >= 0));
            chk("wdata_mux", 32'(o_fifo_wdata), 32'(exp_wd));

            acked_mask = '0;
            if (m_owner < 0) begin
                m_owner = pick(i_req, m_ptr);
                m_beats = 0;
            end else begin
                acc = i_req[m_owner] && !i_fifo_full;
                if (acc) begin
                    oh = '0;
                    oh[m_owner] = 1'b1;
                    exp_q.push_back({oh, i_data[m_owner*W +: W]});
                    m_beats++;
                    acked_mask[m_owner] = 1'b1;
                end
                if (!i_req[m_owner] || (acc && m_beats == BURST)) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = pick(i_req, m_ptr);
                    m_beats = 0;
                end
            end
        end
    end

    // ---------------- monitor (negedge + 1) ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("we_eq_or_ack", 32'(o_fifo_we), 32'(|o_ack));
            if (o_fifo_we || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(o_ack), 32'(0));
                end else begin
                    logic [N+W-1:0] e;
                    e = exp_q.pop_front();
                    chk("write_ack", 32'(o_ack), 32'(e[N+W-1:W]));
                    chk("write_data", 32'(o_fifo_wdata), 32'(e[W-1:0]));
                end
            end
            for (int i = 0; i < N; i++) if (o_ack[i]) ack_cnt[i]++;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [N-1:0] req, input logic full, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            // New data only for lanes that are idle or just had a beat taken.
            for (int i = 0; i < N; i++) begin
                if (!i_req[i] || acked_mask[i]) i_data[i*W +: W] = W'($urandom);
            end
            i_req       = req;
            i_fifo_full = full;
        end
    endtask

    // Reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
        chk("rst_gnt", 32'(o_gnt), 32'(0));
        chk("rst_ack", 32'(o_ack), 32'(0));
        chk("rst_we", 32'(o_fifo_we), 32'(0));
        chk("rst_wdata", 32'(o_fifo_wdata), 32'(0));
        i_req       = '0;
        i_fifo_full = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        clear_counts();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn        = 1'b1;
        i_req       = '0;
        i_data      = '0;
        i_fifo_full = 1'b0;
        clear_counts();
        #1;
        chk("init_gnt", 32'(o_gnt), 32'(0));
        chk("init_busy", 32'(o_busy), 32'(0));
        chk("init_we", 32'(o_fifo_we), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b0;

        // Single requester: 9 acks in 10 cycles, bursts re-granted back to back.
        drive(4'b0001, 1'b0, 10);
        drive(4'b0000, 1'b0, 2);
        chk("single_acks", 32'(ack_cnt[0]), 32'(9));

        // Fairness: each requester gets exactly one burst of 4.
        do_reset();
        drive(4'b1111, 1'b0, 17);
        drive(4'b0000, 1'b0, 2);
        for (int i = 0; i < N; i++) chk("fair_acks", 32'(ack_cnt[i]), 32'(BURST));

        // Full stall mid-burst of owner 2.
        do_reset();
        drive(4'b0100, 1'b0, 3);
        drive(4'b0100, 1'b1, 5);
        chk("stall_gnt", 32'(o_gnt), 32'(4'b0100));
        drive(4'b0100, 1'b0, 2);
        drive(4'b0000, 1'b0, 2);
        chk("stall_acks", 32'(ack_cnt[2]), 32'(4));

        // Early drop by owner 1 hands over to 3, then 0 follows 3.
        do_reset();
        drive(4'b0010, 1'b0, 2);
        drive(4'b1000, 1'b0, 1);
        drive(4'b1000, 1'b0, 1);
        chk("drop_gnt", 32'(o_gnt), 32'(4'b1000));
        drive(4'b1000, 1'b0, 1);
        drive(4'b1001, 1'b0, 6);
        drive(4'b0000, 1'b0, 2);
        chk("drop_acks1", 32'(ack_cnt[1]), 32'(1));
        chk("drop_acks3", 32'(ack_cnt[3]), 32'(4));
        chk("drop_acks0", 32'(ack_cnt[0]), 32'(4));

        // Drop while full: grant moves from 0 to 2 without an ack to 0.
        do_reset();
        drive(4'b0001, 1'b0, 1);
        drive(4'b0001, 1'b1, 1);
        drive(4'b0100, 1'b1, 1);
        drive(4'b0100, 1'b0, 1);
        chk("fulldrop_gnt", 32'(o_gnt), 32'(4'b0100));
        chk("fulldrop_ack0", 32'(ack_cnt[0]), 32'(0));
        drive(4'b0100, 1'b0, 2);
        drive(4'b0000, 1'b0, 2);

        // Async reset in the middle of a burst, then grant restarts at 1.
        do_reset();
        drive(4'b1111, 1'b0, 3);
        do_reset();
        drive(4'b0110, 1'b0, 2);
        chk("post_rst_gnt", 32'(o_gnt), 32'(4'b0010));
        drive(4'b0000, 1'b0, 2);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] r;
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) < 6);
            drive(r, ($urandom_range(0, 3) == 0), 1);
        end
        drive(4'b0000, 1'b0, 3);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
